wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the pipeline write-back stage (mux output of the WB stage);
  - the debug unit's register-write requests.
- Pipeline has priority. Debug requests are buffered in a small FIFO.
- A starvation guard forces a one-cycle pipeline stall so queued debug writes always drain.
- Sits between the WB stage and the register file, inside the MIPS top level.

Parameters:
- IO_BUS_SIZE, 32, data width of write-back and debug data.
- REG_ADDR_SIZE, 5, register index width.
- FIFO_DEPTH, 4, debug request FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a queued debug write may lose arbitration before FORCE.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_write_enable  in  1  pipeline WB stage requests a register write this cycle.
- i_wb_reg_addr  in  REG_ADDR_SIZE  pipeline destination register.
- i_wb_data  in  IO_BUS_SIZE  pipeline write-back data.
- i_dbg_valid  in  1  debug write request valid.
- i_dbg_reg_addr  in  REG_ADDR_SIZE  debug destination register.
- i_dbg_data  in  IO_BUS_SIZE  debug write data.
- o_dbg_ready  out  1  FIFO can accept a request; push occurs on valid&&ready.
- o_stall_pipeline  out  1  pipeline must hold WB stage and re-present its write next cycle.
- o_rf_write_enable  out  1  registered register-file write enable.
- o_rf_reg_addr  out  REG_ADDR_SIZE  registered register-file address.
- o_rf_data  out  IO_BUS_SIZE  registered register-file data.
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, i_reset=1 at edge):
  - FIFO emptied; starve counter = 0; FSM = NORMAL.
  - o_rf_write_enable=0, o_rf_reg_addr=0, o_rf_data=0.
  - o_fifo_count=0, o_stall_pipeline=0.
  - o_dbg_ready=0 while i_reset is high.
  - Reset mid-operation discards all queued debug writes.
- o_dbg_ready = !i_reset && (count < FIFO_DEPTH).
  - Combinational from registered count.
  - No push when full, even if a pop occurs the same cycle.
- Push is visible at the FIFO head only from the next cycle; no same-cycle bypass to the write port.
- FSM NORMAL (o_stall_pipeline=0), grant decided each cycle:
  - i_wb_write_enable=1: pipeline granted. If FIFO non-empty, starve counter +1.
  - else if FIFO non-empty: head popped and granted; starve counter cleared.
  - else: no grant; starve counter cleared.
  - If the counter increment reaches STARVE_LIMIT: next state FORCE, counter cleared.
- FSM FORCE (o_stall_pipeline=1, combinational from state), lasts exactly one cycle:
  - i_wb_write_enable is ignored; the pipeline re-presents that write next cycle.
  - FIFO head popped and granted.
  - Next state NORMAL.
- Write port:
  - Granted request registered onto o_rf_*; 1-cycle latency from grant.
  - o_rf_write_enable=1 only if the granted address != 0. Writes to $zero are dropped but still consume the grant/pop.
  - With no grant, o_rf_write_enable=0; o_rf_reg_addr/o_rf_data hold their last values.
- Same-register conflict in one cycle: pipeline written first, debug write later; the later write wins.
- Count arithmetic per cycle: count + push - pop. Head and tail pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.

Test Plan:
- Reset: after i_reset high 2 cycles -> all o_rf_* =0, o_fifo_count=0, o_dbg_ready=0; deassert -> o_dbg_ready=1.
- Pipeline only: wb_we=1, addr=5, data=0xDEADBEEF -> next cycle rf_we=1, addr=5, data=0xDEADBEEF; addr=0 -> rf_we=0.
- Debug in idle: push (addr=3, data=0x12345678) with wb_we=0 -> count=1, then pop next cycle -> rf write addr=3 one cycle later; count=0.
- Starvation: push 1 debug write, hold wb_we=1 continuously, STARVE_LIMIT=4 -> o_stall_pipeline=1 for exactly one cycle after 4 lost cycles; the debug write appears on o_rf_*; the held pipeline write follows next cycle.
- Full FIFO: 4 pushes with wb_we=1 -> count=4, o_dbg_ready=0; 5th valid not accepted; drain order equals push order (FIFO), pointers wrap correctly on refill.
- Reset mid-operation: 3 queued entries, assert reset -> count=0, no further debug writes appear, FSM NORMAL.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle between the WB stage, the debug unit and the arbiter.
// The master drives the requests; the slave (arbiter) answers with the write port and FIFO status.
interface wb_port_arbiter_if #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int REG_ADDR_SIZE = 5,
    parameter int FIFO_DEPTH    = 4
);
    logic                         i_wb_write_enable;
    logic [REG_ADDR_SIZE-1:0]     i_wb_reg_addr;
    logic [IO_BUS_SIZE-1:0]       i_wb_data;
    logic                         i_dbg_valid;
    logic [REG_ADDR_SIZE-1:0]     i_dbg_reg_addr;
    logic [IO_BUS_SIZE-1:0]       i_dbg_data;
    logic                         o_dbg_ready;
    logic                         o_stall_pipeline;
    logic                         o_rf_write_enable;
    logic [REG_ADDR_SIZE-1:0]     o_rf_reg_addr;
    logic [IO_BUS_SIZE-1:0]       o_rf_data;
    logic [$clog2(FIFO_DEPTH):0]  o_fifo_count;

    modport master (
        output i_wb_write_enable, i_wb_reg_addr, i_wb_data,
        output i_dbg_valid, i_dbg_reg_addr, i_dbg_data,
        input  o_dbg_ready, o_stall_pipeline,
        input  o_rf_write_enable, o_rf_reg_addr, o_rf_data, o_fifo_count
    );

    modport slave (
        input  i_wb_write_enable, i_wb_reg_addr, i_wb_data,
        input  i_dbg_valid, i_dbg_reg_addr, i_dbg_data,
        output o_dbg_ready, o_stall_pipeline,
        output o_rf_write_enable, o_rf_reg_addr, o_rf_data, o_fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (priority) and a FIFO of
// debug writes; a starvation guard stalls the pipeline for one cycle to drain the FIFO.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_NORMAL | pipeline wins the port; FIFO head drains when pipeline idle
//   ST_FORCE  | one-cycle pipeline stall; FIFO head is granted unconditionally
module wb_port_arbiter #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int REG_ADDR_SIZE = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_t;

    state_t                    state_q, state_d;
    logic [REG_ADDR_SIZE-1:0]  fifo_addr [FIFO_DEPTH];
    logic [IO_BUS_SIZE-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          head_q, tail_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [STARVE_W-1:0]       starve_q, starve_d, starve_inc;
    logic                      fifo_empty, dbg_ready, push, pop, grant;
    logic [REG_ADDR_SIZE-1:0]  grant_addr;
    logic [IO_BUS_SIZE-1:0]    grant_data;
    logic                      rf_we_q;
    logic [REG_ADDR_SIZE-1:0]  rf_addr_q;
    logic [IO_BUS_SIZE-1:0]    rf_data_q;

    assign fifo_empty = (count_q == '0);
    // Readiness looks only at the registered count, so a pop cannot make room for a same-cycle push.
    assign dbg_ready  = !i_reset && (count_q < CNT_W'(FIFO_DEPTH));
    assign push       = bus.i_dbg_valid && dbg_ready;
    assign starve_inc = starve_q + STARVE_W'(1);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        pop        = 1'b0;
        grant      = 1'b0;
        grant_addr = bus.i_wb_reg_addr;
        grant_data = bus.i_wb_data;
        case (state_q)
            ST_NORMAL: begin
                if (bus.i_wb_write_enable) begin
                    grant = 1'b1;
                    if (!fifo_empty) begin
                        if (starve_inc == STARVE_W'(STARVE_LIMIT)) begin
                            state_d  = ST_FORCE;
                            starve_d = '0;
                        end else begin
                            starve_d = starve_inc;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    grant      = 1'b1;
                    grant_addr = fifo_addr[head_q];
                    grant_data = fifo_data[head_q];
                    starve_d   = '0;
                end else begin
                    starve_d = '0;
                end
            end
            ST_FORCE: begin
                state_d  = ST_NORMAL;
                starve_d = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    grant      = 1'b1;
                    grant_addr = fifo_addr[head_q];
                    grant_data = fifo_data[head_q];
                end
            end
            default: state_d = ST_NORMAL;
        endcase
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_NORMAL;
            starve_q  <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            if (grant) begin
                // A grant to $zero still consumes the slot; only the enable is suppressed.
                rf_we_q   <= (grant_addr != '0);
                rf_addr_q <= grant_addr;
                rf_data_q <= grant_data;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[tail_q] <= bus.i_dbg_reg_addr;
            fifo_data[tail_q] <= bus.i_dbg_data;
        end
    end

    assign bus.o_dbg_ready       = dbg_ready;
    assign bus.o_stall_pipeline  = (state_q == ST_FORCE);
    assign bus.o_rf_write_enable = rf_we_q;
    assign bus.o_rf_reg_addr     = rf_addr_q;
    assign bus.o_rf_data         = rf_data_q;
    assign bus.o_fifo_count      = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for starvation, full FIFO with wrap, and reset mid-operation.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .FIFO_DEPTH(4)) bus ();

    wb_port_arbiter #(
        .IO_BUS_SIZE(32), .REG_ADDR_SIZE(5), .FIFO_DEPTH(4), .STARVE_LIMIT(4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Inputs held for one cycle, then outputs expected #1 after the following rising edge.
    typedef struct {
        logic        rst;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        dv;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_count;
        logic        e_ready;
        logic        e_stall;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        rst                   = v.rst;
        bus.i_wb_write_enable = v.wb_we;
        bus.i_wb_reg_addr     = v.wb_addr;
        bus.i_wb_data         = v.wb_data;
        bus.i_dbg_valid       = v.dv;
        bus.i_dbg_reg_addr    = v.dbg_addr;
        bus.i_dbg_data        = v.dbg_data;
        @(posedge clk);
        #1;
        chk({tag, " rf_we"},    32'(bus.o_rf_write_enable), 32'(v.e_we));
        chk({tag, " rf_addr"},  32'(bus.o_rf_reg_addr),     32'(v.e_addr));
        chk({tag, " rf_data"},  bus.o_rf_data,              v.e_data);
        chk({tag, " count"},    32'(bus.o_fifo_count),      32'(v.e_count));
        chk({tag, " dbg_ready"},32'(bus.o_dbg_ready),       32'(v.e_ready));
        chk({tag, " stall"},    32'(bus.o_stall_pipeline),  32'(v.e_stall));
    endtask

    initial begin
        //            rst we wa     wd            dv da     dd            | we a      d             cnt  rdy  stl
        tbl[0]  = '{1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 32'h0,        3'd0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 32'h0,        3'd0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 32'h0,        3'd0,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0,32'h0,        1'b1,5'd5, 32'hDEADBEEF, 3'd0,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,5'd0, 32'h11111111, 1'b0,5'd0,32'h0,        1'b0,5'd0, 32'h11111111, 3'd0,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 32'h11111111, 3'd0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd3,32'h12345678, 1'b0,5'd0, 32'h11111111, 3'd1,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd3, 32'h12345678, 3'd0,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd3, 32'h12345678, 3'd0,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,5'd7, 32'hAAAA0001, 1'b1,5'd7,32'hBBBB0002, 1'b1,5'd7, 32'hAAAA0001, 3'd1,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd7, 32'hBBBB0002, 3'd0,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd4,32'h00000004, 1'b0,5'd7, 32'hBBBB0002, 3'd1,1'b1,1'b0};
        tbl[12] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd6,32'h00000006, 1'b1,5'd4, 32'h00000004, 3'd1,1'b1,1'b0};
        tbl[13] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd6, 32'h00000006, 3'd0,1'b1,1'b0};
        tbl[14] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0,32'hDDDD0000, 1'b0,5'd6, 32'h00000006, 3'd1,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 32'hDDDD0000, 3'd0,1'b1,1'b0};

        for (int i = 0; i < 16; i++)
            apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Starvation: one queued debug write loses four cycles, then a single FORCE cycle drains it.
        apply_vec('{1'b0,1'b1,5'd9,32'h90000000,1'b1,5'd2,32'h22222222, 1'b1,5'd9,32'h90000000,3'd1,1'b1,1'b0}, "starve0");
        apply_vec('{1'b0,1'b1,5'd9,32'h90000001,1'b0,5'd0,32'h0,        1'b1,5'd9,32'h90000001,3'd1,1'b1,1'b0}, "starve1");
        apply_vec('{1'b0,1'b1,5'd9,32'h90000002,1'b0,5'd0,32'h0,        1'b1,5'd9,32'h90000002,3'd1,1'b1,1'b0}, "starve2");
        apply_vec('{1'b0,1'b1,5'd9,32'h90000003,1'b0,5'd0,32'h0,        1'b1,5'd9,32'h90000003,3'd1,1'b1,1'b0}, "starve3");
        apply_vec('{1'b0,1'b1,5'd9,32'h90000004,1'b0,5'd0,32'h0,        1'b1,5'd9,32'h90000004,3'd1,1'b1,1'b1}, "starve4");
        apply_vec('{1'b0,1'b1,5'd9,32'h95555555,1'b0,5'd0,32'h0,        1'b1,5'd2,32'h22222222,3'd0,1'b1,1'b0}, "starve_force");
        apply_vec('{1'b0,1'b1,5'd9,32'h95555555,1'b0,5'd0,32'h0,        1'b1,5'd9,32'h95555555,3'd0,1'b1,1'b0}, "starve_replay");

        // Full FIFO behind a busy pipeline; 5th request refused even in the popping FORCE cycle.
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000000,1'b1,5'd16,32'hC0000000, 1'b1,5'd10,32'hA0000000,3'd1,1'b1,1'b0}, "full0");
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000001,1'b1,5'd17,32'hC0000001, 1'b1,5'd10,32'hA0000001,3'd2,1'b1,1'b0}, "full1");
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000002,1'b1,5'd18,32'hC0000002, 1'b1,5'd10,32'hA0000002,3'd3,1'b1,1'b0}, "full2");
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000003,1'b1,5'd19,32'hC0000003, 1'b1,5'd10,32'hA0000003,3'd4,1'b0,1'b0}, "full3");
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000004,1'b1,5'd20,32'hBADBAD00, 1'b1,5'd10,32'hA0000004,3'd4,1'b0,1'b1}, "full4");
        apply_vec('{1'b0,1'b1,5'd10,32'hA0000005,1'b1,5'd20,32'hBADBAD00, 1'b1,5'd16,32'hC0000000,3'd3,1'b1,1'b0}, "full_force");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd17,32'hC0000001,3'd2,1'b1,1'b0}, "drain1");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd18,32'hC0000002,3'd1,1'b1,1'b0}, "drain2");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd19,32'hC0000003,3'd0,1'b1,1'b0}, "drain3");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b0,5'd19,32'hC0000003,3'd0,1'b1,1'b0}, "drain_empty");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd21,32'hE0000001, 1'b0,5'd19,32'hC0000003,3'd1,1'b1,1'b0}, "refill0");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd22,32'hE0000002, 1'b1,5'd21,32'hE0000001,3'd1,1'b1,1'b0}, "refill1");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b1,5'd22,32'hE0000002,3'd0,1'b1,1'b0}, "refill2");

        // Reset with three queued entries and a partly advanced starve count.
        apply_vec('{1'b0,1'b1,5'd11,32'hB0000000,1'b1,5'd24,32'hD0000001, 1'b1,5'd11,32'hB0000000,3'd1,1'b1,1'b0}, "mid0");
        apply_vec('{1'b0,1'b1,5'd11,32'hB0000001,1'b1,5'd25,32'hD0000002, 1'b1,5'd11,32'hB0000001,3'd2,1'b1,1'b0}, "mid1");
        apply_vec('{1'b0,1'b1,5'd11,32'hB0000002,1'b1,5'd26,32'hD0000003, 1'b1,5'd11,32'hB0000002,3'd3,1'b1,1'b0}, "mid2");
        apply_vec('{1'b1,1'b1,5'd11,32'hB0000003,1'b1,5'd27,32'hD0000004, 1'b0,5'd0, 32'h0,       3'd0,1'b0,1'b0}, "mid_reset");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000004,1'b1,5'd28,32'hD0000005, 1'b1,5'd12,32'hB0000004,3'd1,1'b1,1'b0}, "post0");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000005,1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hB0000005,3'd1,1'b1,1'b0}, "post1");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000006,1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hB0000006,3'd1,1'b1,1'b0}, "post2");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000007,1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hB0000007,3'd1,1'b1,1'b0}, "post3");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000008,1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hB0000008,3'd1,1'b1,1'b1}, "post4");
        apply_vec('{1'b0,1'b1,5'd12,32'hB0000009,1'b0,5'd0, 32'h0,        1'b1,5'd28,32'hD0000005,3'd0,1'b1,1'b0}, "post_force");
        apply_vec('{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,        1'b0,5'd28,32'hD0000005,3'd0,1'b1,1'b0}, "post_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
